// File: rtl/trace_pkg.sv
// Shared types for the commit trace port.
// Entry layout, FSM states and default end address.
package trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    localparam logic [31:0] DEFAULT_END_ADDR = 32'h0000_4000;
    localparam int ENTRY_W = 97;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Trace entry FIFO: two write ports, one read port.
// Storage is cleared on reset so the head reads zero afterwards.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push0,
    input  logic                       push1,
    input  entry_t                     din0,
    input  entry_t                     din1,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;

    // push1 is only ever raised together with push0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push0) begin
                mem[wptr] <= din0;
            end
            if (push1) begin
                mem[wptr + AW'(1)] <= din1;
            end
            wptr  <= wptr + AW'(push0) + AW'(push1);
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/commit_trace_port.sv
// Commit trace writer: buffers GRF/DM write events for an external
// consumer and signals done once the program has ended and drained.
module commit_trace_port
    import trace_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] END_ADDR = DEFAULT_END_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        grf_we,
    input  logic [4:0]  grf_addr,
    input  logic [31:0] grf_wdata,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        stall,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic        trace_kind,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        done
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] HIWAT = CW'(DEPTH - 2);

    state_t        state;
    logic [CW-1:0] count;
    entry_t        head;
    entry_t        grf_e;
    entry_t        dm_e;
    logic          run;
    logic          grf_ev;
    logic          dm_ev;
    logic          push0;
    logic          push1;
    logic          pop;
    logic          end_hit;
    logic          drained;

    // Two free slots are kept so a dual write never overflows
    assign stall = (state != ST_RUN) || (count > HIWAT);
    assign run   = (state == ST_RUN) && !stall;

    assign grf_ev = run && grf_we && (grf_addr != 5'd0);
    assign dm_ev  = run && dm_we;

    assign grf_e = '{kind: KIND_GRF, pc: pc,
                     addr: {27'd0, grf_addr}, data: grf_wdata};
    assign dm_e  = '{kind: KIND_DM, pc: pc,
                     addr: dm_addr, data: dm_wdata};

    assign push0 = grf_ev || dm_ev;
    assign push1 = grf_ev && dm_ev;

    assign trace_valid = (count != '0);
    assign pop         = trace_valid && trace_ready;

    assign end_hit = run &&
        (({1'b0, pc} + 33'd4) >= {1'b0, END_ADDR});

    // No pushes happen outside RUN, so only the pop can empty it
    assign drained = (count == '0) || ((count == CW'(1)) && pop);

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (push0),
        .push1 (push1),
        .din0  (grf_ev ? grf_e : dm_e),
        .din1  (dm_e),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            done  <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (end_hit) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign trace_kind = head.kind;
    assign trace_pc   = head.pc;
    assign trace_addr = head.addr;
    assign trace_data = head.data;

endmodule

// File: tb/tb_commit_trace_port.sv
// Randomized and directed bench for commit_trace_port.
// A queue-based model of the trace stream is checked every cycle.
module tb_commit_trace_port;

    localparam int DEPTH = 4;
    localparam logic [31:0] END_A = 32'h0000_4000;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        stall;
    logic        trace_valid;
    logic        trace_ready;
    logic        trace_kind;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        done;

    commit_trace_port #(
        .DEPTH    (DEPTH),
        .END_ADDR (END_A)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .grf_we      (grf_we),
        .grf_addr    (grf_addr),
        .grf_wdata   (grf_wdata),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .stall       (stall),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_kind  (trace_kind),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    // Model: ordered list of undelivered events plus program phase
    // (0 = running, 1 = ended and draining, 2 = finished).
    ev_t q[$];
    int  phase;

    task automatic check_outputs();
        logic es;
        es = (phase != 0) || (q.size() > DEPTH - 2);
        chk("stall", 32'(stall), 32'(es));
        chk("valid", 32'(trace_valid), 32'(q.size() > 0));
        chk("done", 32'(done), 32'(phase == 2));
        if (q.size() > 0) begin
            chk("kind", 32'(trace_kind), 32'(q[0].kind));
            chk("pc", trace_pc, q[0].pc);
            chk("addr", trace_addr, q[0].addr);
            chk("data", trace_data, q[0].data);
        end
    endtask

    task automatic step(input logic [31:0] p,
                        input logic gwe, input logic [4:0] ga,
                        input logic [31:0] gd,
                        input logic dwe, input logic [31:0] da,
                        input logic [31:0] dd,
                        input logic rdy);
        logic accept;
        logic popm;
        logic ended;
        ev_t  ge;
        ev_t  de;
        pc = p; grf_we = gwe; grf_addr = ga; grf_wdata = gd;
        dm_we = dwe; dm_addr = da; dm_wdata = dd;
        trace_ready = rdy;
        #1;
        check_outputs();
        accept = (phase == 0) && (q.size() <= DEPTH - 2);
        popm   = (q.size() > 0) && rdy;
        ended  = (33'(p) + 33'd4) >= 33'(END_A);
        ge = '{kind: 1'b0, pc: p, addr: 32'(ga), data: gd};
        de = '{kind: 1'b1, pc: p, addr: da, data: dd};
        @(posedge clk);
        if (popm) q.delete(0);
        if (accept) begin
            if (gwe && ga != 5'd0) q.push_back(ge);
            if (dwe) q.push_back(de);
            if (ended) phase = 1;
        end else if (phase == 1 && q.size() == 0) begin
            phase = 2;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(32'h0000_0100, 1'b0, 5'd0, 32'd0,
             1'b0, 32'd0, 32'd0, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_kind", 32'(trace_kind), 32'd0);
        chk("rst_pc", trace_pc, 32'd0);
        chk("rst_addr", trace_addr, 32'd0);
        chk("rst_data", trace_data, 32'd0);
        q.delete();
        phase = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_stall", 32'(stall), 32'd0);
    endtask

    task automatic rand_step(input int rdy_pct);
        logic [31:0] p;
        p = 32'($urandom_range(0, 32'hFEF)) << 2;
        step(p, 1'($urandom), 5'($urandom), $urandom,
             1'($urandom), $urandom, $urandom,
             $urandom_range(0, 99) < rdy_pct);
    endtask

    initial begin
        reset = 1'b0;
        pc = '0; grf_we = 0; grf_addr = '0; grf_wdata = '0;
        dm_we = 0; dm_addr = '0; dm_wdata = '0; trace_ready = 0;
        phase = 0;
        #1;
        do_reset();

        // $0 write dropped, then a real GRF write
        step(32'h3000, 1, 5'd0, 32'h55, 0, 0, 0, 0);
        chk("zero_drop", 32'(trace_valid), 32'd0);
        step(32'h3000, 1, 5'd8, 32'h12, 0, 0, 0, 0);

        // Dual write, GRF entry first
        step(32'h3004, 1, 5'd2, 32'd5, 1, 32'h10, 32'd7, 1);
        repeat (3) idle(1);

        // Backpressure up to the stall threshold, then drain
        for (int i = 0; i < 6; i++) begin
            step(32'h3008 + 32'(4 * i), 1, 5'(i + 1), 32'(i),
                 0, 0, 0, 0);
        end
        chk("bp_stall", 32'(stall), 32'd1);
        repeat (6) idle(1);

        for (int i = 0; i < 400; i++) begin
            rand_step(i < 200 ? 50 : 85);
        end
        repeat (6) idle(1);

        // End of program with a pending DM write
        step(32'h3FFC, 0, 5'd0, 0, 1, 32'h20, 32'h99, 0);
        repeat (2) idle(0);
        repeat (4) idle(1);
        chk("end_done", 32'(done), 32'd1);

        // Near-end PC does not end; end with empty FIFO
        do_reset();
        step(32'h3FF8, 0, 5'd0, 0, 0, 0, 0, 1);
        step(32'h3FFC, 0, 5'd0, 0, 0, 0, 0, 1);
        repeat (3) idle(1);

        // PC wrap is caught by the widened compare
        do_reset();
        step(32'hFFFF_FFFC, 1, 5'd1, 32'hAB, 0, 0, 0, 1);
        repeat (3) idle(1);

        // Reset while draining with two entries buffered
        do_reset();
        step(32'h3FFC, 1, 5'd3, 32'hA, 1, 32'h40, 32'hB, 0);
        idle(0);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rand_step(60);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_port.md
# commit_trace_port

Architectural-commit trace port for the P4 single-cycle MIPS. It captures register-file and data-memory write events with their PC into a small FIFO and presents them to an external consumer over valid/ready. It also detects program end (PC+4 reaching the end of instruction memory), drains the FIFO, and raises `done`. It is the in-design writer that feeds the bench-side trace checker. It sits beside `mips`, fed from the datapath's writeback and DM-write nets.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `END_ADDR`, 32'h0000_4000: first PC past instruction memory.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low; 0 = reset.
- `pc` input 32: PC of the instruction executing this cycle.
- `grf_we` input 1: GRF write this cycle.
- `grf_addr` input 5: GRF destination.
- `grf_wdata` input 32: GRF write data.
- `dm_we` input 1: DM write this cycle.
- `dm_addr` input 32: DM byte address.
- `dm_wdata` input 32: DM write data.
- `stall` output 1: CPU must hold PC and suppress all writes this cycle (combinational).
- `trace_valid` output 1: head entry present.
- `trace_ready` input 1: consumer accepts head.
- `trace_kind` output 1: 0 = GRF, 1 = DM.
- `trace_pc` output 32: PC of the event.
- `trace_addr` output 32: GRF index zero-extended, or DM address.
- `trace_data` output 32: write data.
- `done` output 1: program ended and all events delivered.

## Operation
- States: RUN, DRAIN, DONE. Reset → RUN, FIFO empty.
- Events are accepted only in RUN with `stall`=0.
  - GRF event: `grf_we`=1 and `grf_addr`≠0. Writes to $0 are dropped silently.
  - DM event: `dm_we`=1.
- Both events in one cycle → two pushes, GRF entry ahead of DM entry.
- `stall` = (state≠RUN) or (count > DEPTH−2). Two free slots are always guaranteed, so no overflow is possible.
- Pop on `trace_valid`&&`trace_ready`. Push and pop in the same cycle are both honoured; count changes by pushes−pops.
- End detect: in RUN with `stall`=0, when {1'b0,pc}+33'd4 ≥ {1'b0,END_ADDR} (33-bit compare, no wrap):
  - that cycle's events are still pushed;
  - next state is DRAIN.
- DRAIN: writes ignored and `stall`=1. Moves to DONE on the cycle count reaches 0 (after the last pop).
- DONE: absorbing until reset. `done`=1, `stall`=1, `trace_valid`=0.
- Head fields are driven from FIFO storage. When `trace_valid`=0 they hold the last value and carry no meaning.

## Timing
- Reset values: `trace_valid`=0, `done`=0, `trace_kind`=0, `trace_pc`/`trace_addr`/`trace_data`=0. `stall`=0 once reset is released (RUN, empty).
- Reset is asserted asynchronously and released synchronously to `clk` by the upstream reset logic. Mid-operation reset flushes the FIFO and returns the block to RUN; buffered events are lost.
- Latency: an event pushed at edge N appears at the head (`trace_valid`=1) after edge N, i.e. in the same cycle as the following instruction.
- `trace_*` remain stable while `trace_valid`=1 and `trace_ready`=0.
- `stall` is combinational from count and state only; it never depends on `trace_ready`, so there is no combinational path from `trace_ready` to the CPU.
- `done` rises one cycle after the final pop.
- If the end condition holds with the FIFO already empty and no event that cycle: DRAIN lasts one cycle, then DONE.

## Structure
- Package `trace_pkg` holds:
  - `KIND_GRF`=1'b0 and `KIND_DM`=1'b1;
  - the RUN/DRAIN/DONE state encoding;
  - `DEFAULT_END_ADDR`;
  - the entry width (1+32+32+32 = 97).
- Sub-module `trace_fifo`: DEPTH×97 storage with 2-write/1-read ports, wrap-around pointers, and a count of width clog2(DEPTH+1).
- The top level holds the FSM, event qualification, and `stall`/`done` logic.

## Test plan
- $0 drop: `grf_we`=1, `grf_addr`=0, `pc`=0x3000 → no push, `trace_valid` stays 0. Then `grf_addr`=8, `grf_wdata`=0x12 → next cycle head is kind 0, pc 0x3000, addr 8, data 0x12.
- Dual write with ordering: `grf_we`+`dm_we` at pc 0x3004 (reg 2 = 5; mem 0x10 = 7) with `trace_ready`=1 → GRF entry delivered first, then DM entry on the following cycle.
- Backpressure: `trace_ready`=0, GRF write every unstalled cycle, DEPTH=4 → `stall` rises when count=3. Raising `trace_ready` drains entries in order, stall clears at count≤2, and nothing is lost or duplicated.
- End of program: pc 0x3FFC with DM write and `trace_ready`=0 → state DRAIN, `stall`=1. Asserting `trace_ready` → last entry popped, `done`=1 one cycle later, `trace_valid`=0.
- PC wrap: pc 0xFFFF_FFFC → end detected (33-bit compare); the block does not stay in RUN.
- Reset mid-DRAIN with 2 entries buffered: `reset`=0 → `trace_valid`=0, `done`=0, and `stall`=0 after release.
